// File: rtl/gsm_cmd_sched_if.sv
// gsm_cmd_sched_if: script ROM fetch and UART valid/ready transmit bus
interface gsm_cmd_sched_if #(parameter int ADDR_W = 8);
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0] rom_data;
  logic [7:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  modport master(output rom_addr, tx_data, tx_valid, input rom_data, tx_ready);
  modport slave(input rom_addr, tx_data, tx_valid, output rom_data, tx_ready);
endinterface

// File: rtl/gsm_cmd_sched.sv
// gsm_cmd_sched: call/SMS AT-script scheduler feeding the UART; GSM_OK_WAIT_EN replaces the post-CR delay with an "OK" wait plus timeout
module gsm_cmd_sched #(
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] CALL_BASE = 'h00,
  parameter logic [ADDR_W-1:0] SMS_BASE = 'h40,
  parameter int DELAY_CNT = 12000000,
  parameter logic [7:0] TERM_BYTE = 8'h00
) (
  input logic clk,
  input logic rst,
  input logic call_req,
  input logic sms_req,
  input logic abort,
`ifdef GSM_OK_WAIT_EN
  input logic [7:0] rx_data,
  input logic rx_valid,
  output logic error,
`endif
  gsm_cmd_sched_if.master bus,
  output logic busy,
  output logic active_sms,
  output logic done,
  output logic aborted
);
  typedef enum logic [2:0] {IDLE, FETCH, CHECK, SEND, GAP} state_t;
  state_t state;
  logic pend_call, pend_sms;
  logic [23:0] cnt;
  logic grant_call, grant_sms, gap_end;
`ifdef GSM_OK_WAIT_EN
  logic got_o;
`endif
  assign grant_call = state == IDLE && pend_call;
  assign grant_sms = state == IDLE && !pend_call && pend_sms;
  assign gap_end = cnt == 24'(DELAY_CNT - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pend_call <= 1'b0;
      pend_sms <= 1'b0;
      cnt <= '0;
      bus.rom_addr <= '0;
      bus.tx_data <= '0;
      bus.tx_valid <= 1'b0;
      busy <= 1'b0;
      active_sms <= 1'b0;
      done <= 1'b0;
      aborted <= 1'b0;
`ifdef GSM_OK_WAIT_EN
      error <= 1'b0;
      got_o <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      aborted <= 1'b0;
`ifdef GSM_OK_WAIT_EN
      error <= 1'b0;
`endif
      pend_call <= call_req | (pend_call & !grant_call);
      pend_sms <= sms_req | (pend_sms & !grant_sms);
      case (state)
        IDLE: if (grant_call || grant_sms) begin
          state <= FETCH;
          busy <= 1'b1;
          active_sms <= grant_sms;
          bus.rom_addr <= grant_sms ? SMS_BASE : CALL_BASE;
        end
        FETCH: state <= CHECK;
        CHECK: if (abort) begin
          state <= IDLE;
          busy <= 1'b0;
          aborted <= 1'b1;
        end else if (bus.rom_data == TERM_BYTE) begin
          state <= IDLE;
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          bus.tx_data <= bus.rom_data;
          bus.tx_valid <= 1'b1;
          state <= SEND;
        end
        SEND: if (bus.tx_ready) begin
          bus.tx_valid <= 1'b0;
          bus.rom_addr <= bus.rom_addr + 1'b1;
          state <= bus.tx_data == 8'h0D ? GAP : FETCH;
          cnt <= '0;
`ifdef GSM_OK_WAIT_EN
          got_o <= 1'b0;
`endif
        end
`ifdef GSM_OK_WAIT_EN
        GAP: if (abort) begin
          state <= IDLE;
          busy <= 1'b0;
          aborted <= 1'b1;
        end else if (rx_valid && rx_data == "K" && got_o) begin
          state <= FETCH;
        end else if (gap_end) begin
          state <= IDLE;
          busy <= 1'b0;
          error <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
          got_o <= rx_valid ? rx_data == "O" : got_o;
        end
`else
        GAP: if (abort) begin
          state <= IDLE;
          busy <= 1'b0;
          aborted <= 1'b1;
        end else if (gap_end) begin
          state <= FETCH;
        end else begin
          cnt <= cnt + 1'b1;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule
